// File: rtl/friscv_rv32i_control.sv
// friscv RV32I front-end control: owns the PC, fetches and decodes,
// queues ALU-class instructions and executes control flow locally.
`ifndef ALU_FIFO_DEPTH
`define ALU_FIFO_DEPTH 4
`endif
`ifndef ALU_INSTBUS_W
`define ALU_INSTBUS_W 86
`endif

module friscv_rv32i_control #(
    parameter int ADDRW     = 16,
    parameter int BOOT_ADDR = 0,
    parameter int XLEN      = 32
)(
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      srst,
    output logic                      inst_en,
    output logic [ADDRW-1:0]          inst_addr,
    input  logic [XLEN-1:0]           inst_rdata,
    input  logic                      inst_ready,
    output logic                      alu_en,
    input  logic                      alu_ready,
    output logic [`ALU_INSTBUS_W-1:0] alu_instbus,
    output logic [4:0]                ctrl_rs1_addr,
    input  logic [XLEN-1:0]           ctrl_rs1_val,
    output logic [4:0]                ctrl_rs2_addr,
    input  logic [XLEN-1:0]           ctrl_rs2_val,
    output logic                      ctrl_rd_wr,
    output logic [4:0]                ctrl_rd_addr,
    output logic [XLEN-1:0]           ctrl_rd_val
);
    localparam int DEPTH = `ALU_FIFO_DEPTH;
    localparam int PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW  = PTRW + 1;
    localparam int BW    = `ALU_INSTBUS_W;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_NOP    = 7'b0000000;

    logic [XLEN-1:0] r_pc;
    logic            r_running;
    logic            r_halted;
    logic            r_rd_wr;
    logic [4:0]      r_rd_addr;
    logic [XLEN-1:0] r_rd_val;
    logic [BW-1:0]   r_fifo [DEPTH];
    logic [PTRW-1:0] r_wptr;
    logic [PTRW-1:0] r_rptr;
    logic [CNTW-1:0] r_count;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rd;
    logic [11:0]     w_imm12;
    logic            w_auipc, w_jal, w_jalr, w_branch;
    logic            w_is_alu, w_is_cf, w_is_nop;
    logic            w_inst_error;
    logic            w_fifo_full, w_fifo_empty;
    logic            w_hs, w_alu_wr, w_pop;
    logic [BW-1:0]   w_bus;
    logic [XLEN-1:0] w_imm_u, w_imm_j, w_imm_b, w_imm_i;
    logic [XLEN-1:0] w_pc_inc, w_jalr_t;
    logic            w_taken;
    logic [XLEN-1:0] w_pc_next;
    logic            w_rd_wr;
    logic [XLEN-1:0] w_rd_val;

    assign w_opcode = inst_rdata[6:0];
    assign w_funct3 = inst_rdata[14:12];
    assign w_rd     = inst_rdata[11:7];
    assign w_auipc  = (w_opcode == OP_AUIPC);
    assign w_jal    = (w_opcode == OP_JAL);
    assign w_jalr   = (w_opcode == OP_JALR);
    assign w_branch = (w_opcode == OP_BRANCH);
    assign w_is_nop = (w_opcode == OP_NOP);
    assign w_is_cf  = w_auipc | w_jal | w_jalr | w_branch;
    assign w_is_alu = (w_opcode == OP_LUI) | (w_opcode == OP_LOAD)
                    | (w_opcode == OP_STORE) | (w_opcode == OP_OPIMM)
                    | (w_opcode == OP_OP) | (w_opcode == OP_SYSTEM);
    assign w_inst_error = ~(w_is_alu | w_is_cf | w_is_nop);

    assign w_fifo_full  = (r_count == CNTW'(DEPTH));
    assign w_fifo_empty = (r_count == '0);

    // Control flow must wait for older ALU work to drain
    assign inst_en  = r_running & ~r_halted & ~w_fifo_full
                    & ~(w_is_cf & ~w_fifo_empty);
    assign inst_addr = r_pc[ADDRW-1:0];
    assign w_hs      = inst_en & inst_ready;
    assign w_alu_wr  = w_hs & w_is_alu;
    assign w_pop     = alu_en & alu_ready;

    assign ctrl_rs1_addr = inst_rdata[19:15];
    assign ctrl_rs2_addr = inst_rdata[24:20];

    assign w_imm12 = (w_opcode == OP_STORE)
                   ? {inst_rdata[31:25], inst_rdata[11:7]}
                   : inst_rdata[31:20];
    assign w_bus = {w_opcode, w_funct3, inst_rdata[31:25],
                    inst_rdata[19:15], inst_rdata[24:20], w_rd,
                    inst_rdata[19:15], w_imm12, inst_rdata[31:12],
                    inst_rdata[31:20], inst_rdata[24:20]};

    assign w_imm_u = {{(XLEN-32){inst_rdata[31]}}, inst_rdata[31:12], 12'b0};
    assign w_imm_j = {{(XLEN-20){inst_rdata[31]}}, inst_rdata[19:12],
                      inst_rdata[20], inst_rdata[30:21], 1'b0};
    assign w_imm_b = {{(XLEN-12){inst_rdata[31]}}, inst_rdata[7],
                      inst_rdata[30:25], inst_rdata[11:8], 1'b0};
    assign w_imm_i = {{(XLEN-12){inst_rdata[31]}}, inst_rdata[31:20]};
    assign w_pc_inc = r_pc + XLEN'(4);
    assign w_jalr_t = ctrl_rs1_val + w_imm_i;

    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = (ctrl_rs1_val == ctrl_rs2_val);
            3'b001:  w_taken = (ctrl_rs1_val != ctrl_rs2_val);
            3'b100:  w_taken = ($signed(ctrl_rs1_val) < $signed(ctrl_rs2_val));
            3'b101:  w_taken = ($signed(ctrl_rs1_val) >= $signed(ctrl_rs2_val));
            3'b110:  w_taken = (ctrl_rs1_val < ctrl_rs2_val);
            3'b111:  w_taken = (ctrl_rs1_val >= ctrl_rs2_val);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_pc_next = r_pc;
        w_rd_wr   = 1'b0;
        w_rd_val  = w_pc_inc;
        if (w_hs) begin
            unique case (1'b1)
                w_is_alu: w_pc_next = w_pc_inc;
                w_auipc: begin
                    w_pc_next = r_pc + w_imm_u;
                    w_rd_wr   = 1'b1;
                    w_rd_val  = r_pc + w_imm_u;
                end
                w_jal: begin
                    w_pc_next = r_pc + w_imm_j;
                    w_rd_wr   = 1'b1;
                end
                w_jalr: begin
                    w_pc_next = w_jalr_t & ~XLEN'(1);
                    w_rd_wr   = 1'b1;
                end
                w_branch: w_pc_next = w_taken ? (r_pc + w_imm_b) : w_pc_inc;
                default: w_pc_next = r_pc;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pc      <= XLEN'(BOOT_ADDR);
            r_running <= 1'b0;
            r_halted  <= 1'b0;
            r_rd_wr   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_val  <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else if (srst) begin
            r_pc      <= XLEN'(BOOT_ADDR);
            r_running <= 1'b0;
            r_halted  <= 1'b0;
            r_rd_wr   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_val  <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            r_running <= 1'b1;
            if (w_hs && w_inst_error) r_halted <= 1'b1;
            r_pc    <= w_pc_next;
            r_rd_wr <= w_rd_wr;
            if (w_rd_wr) begin
                r_rd_addr <= w_rd;
                r_rd_val  <= w_rd_val;
            end
            if (w_alu_wr)
                r_wptr <= (r_wptr == PTRW'(DEPTH-1)) ? '0 : r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= (r_rptr == PTRW'(DEPTH-1)) ? '0 : r_rptr + 1'b1;
            if (w_alu_wr && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_alu_wr && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_alu_wr) r_fifo[r_wptr] <= w_bus;
    end

    assign alu_en       = ~w_fifo_empty;
    assign alu_instbus  = r_fifo[r_rptr];
    assign ctrl_rd_wr   = r_rd_wr;
    assign ctrl_rd_addr = r_rd_addr;
    assign ctrl_rd_val  = r_rd_val;
endmodule

// File: tb/tb_friscv_rv32i_control.sv
// Scoreboard bench for friscv_rv32i_control: random and directed
// instruction streams against an instruction-level reference model.
`timescale 1ns/1ps
module tb_friscv_rv32i_control;
    localparam int BW = 86;
    localparam int DEPTH = 4;

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F;
    localparam logic [6:0] JALR = 7'h67, BRANCH = 7'h63, LOAD = 7'h03;
    localparam logic [6:0] STORE = 7'h23, OPIMM = 7'h13, OP = 7'h33;
    localparam logic [6:0] SYSTEM = 7'h73, NOP = 7'h00;

    logic aclk = 1'b0, aresetn = 1'b0, srst = 1'b0;
    logic inst_en, inst_ready = 1'b0, alu_en, alu_ready = 1'b0;
    logic [15:0] inst_addr;
    logic [31:0] inst_rdata = '0;
    logic [BW-1:0] alu_instbus;
    logic [4:0] ctrl_rs1_addr, ctrl_rs2_addr, ctrl_rd_addr;
    logic [31:0] ctrl_rs1_val = '0, ctrl_rs2_val = '0, ctrl_rd_val;
    logic ctrl_rd_wr;

    always #5 aclk = ~aclk;

    friscv_rv32i_control dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .inst_en(inst_en), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata), .inst_ready(inst_ready),
        .alu_en(alu_en), .alu_ready(alu_ready), .alu_instbus(alu_instbus),
        .ctrl_rs1_addr(ctrl_rs1_addr), .ctrl_rs1_val(ctrl_rs1_val),
        .ctrl_rs2_addr(ctrl_rs2_addr), .ctrl_rs2_val(ctrl_rs2_val),
        .ctrl_rd_wr(ctrl_rd_wr), .ctrl_rd_addr(ctrl_rd_addr),
        .ctrl_rd_val(ctrl_rd_val)
    );

    int n_checks = 0, n_fail = 0;
    logic [BW-1:0] alu_q[$];
    logic [36:0] rd_q[$];
    logic [31:0] prog[$];
    logic [31:0] m_pc = '0;
    bit m_run = 0, m_halt = 0, directed = 0, zero_rs = 0;
    int ready_mode = -1, alu_mode = -1;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit is_alu(logic [6:0] o);
        return o == LUI || o == LOAD || o == STORE || o == OPIMM
            || o == OP || o == SYSTEM;
    endfunction
    function automatic bit is_cf(logic [6:0] o);
        return o == AUIPC || o == JAL || o == JALR || o == BRANCH;
    endfunction
    function automatic bit is_legal(logic [6:0] o);
        return is_alu(o) || is_cf(o) || o == NOP;
    endfunction

    function automatic logic [6:0] pick_op(int k);
        case (k)
            0: return LUI;    1: return AUIPC;  2: return JAL;
            3: return JALR;   4: return BRANCH; 5: return LOAD;
            6: return STORE;  7: return OPIMM;  8: return OP;
            9: return SYSTEM; 10: return NOP;   11: return 7'h01;
            12: return 7'h29; default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = ($urandom_range(0, 199) == 0) ? $urandom_range(11, 13)
                                          : $urandom_range(0, 10);
        r[6:0] = pick_op(k);
        if (r[6:0] == BRANCH) begin
            k = $urandom_range(0, 5);
            r[14:12] = (k < 2) ? 3'(k) : 3'(k + 2);
        end
        return r;
    endfunction

    // Decoded view an ALU unit expects for instruction i
    function automatic logic [BW-1:0] exp_bus(logic [31:0] i);
        logic [11:0] imm;
        imm = (i[6:0] == STORE) ? {i[31:25], i[11:7]} : i[31:20];
        return {i[6:0], i[14:12], i[31:25], i[19:15], i[24:20], i[11:7],
                i[19:15], imm, i[31:12], i[31:20], i[24:20]};
    endfunction

    task automatic model_step(logic [31:0] i);
        logic [31:0] a, b, joff, boff, iimm;
        bit t;
        a = ctrl_rs1_val;
        b = ctrl_rs2_val;
        joff = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        boff = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        iimm = {{20{i[31]}}, i[31:20]};
        if (!is_legal(i[6:0])) m_halt = 1;
        else if (is_alu(i[6:0])) begin
            alu_q.push_back(exp_bus(i));
            m_pc = m_pc + 4;
        end else if (i[6:0] == AUIPC) begin
            m_pc = m_pc + {i[31:12], 12'h000};
            rd_q.push_back({i[11:7], m_pc});
        end else if (i[6:0] == JAL) begin
            rd_q.push_back({i[11:7], m_pc + 32'd4});
            m_pc = m_pc + joff;
        end else if (i[6:0] == JALR) begin
            rd_q.push_back({i[11:7], m_pc + 32'd4});
            m_pc = (a + iimm) & 32'hFFFF_FFFE;
        end else if (i[6:0] == BRANCH) begin
            case (i[14:12])
                3'd0: t = a == b;
                3'd1: t = a != b;
                3'd4: t = $signed(a) < $signed(b);
                3'd5: t = $signed(a) >= $signed(b);
                3'd6: t = a < b;
                3'd7: t = a >= b;
                default: t = 0;
            endcase
            m_pc = t ? m_pc + boff : m_pc + 4;
        end
    endtask

    task automatic run_cycles(int n);
        bit exp_en;
        repeat (n) begin
            @(negedge aclk);
            alu_ready = (alu_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(alu_mode);
            if (directed && prog.size() == 0) begin
                inst_rdata = '0;
                inst_ready = 1'b0;
            end else begin
                inst_rdata = (prog.size() > 0) ? prog[0] : rand_inst();
                inst_ready = (ready_mode < 0) ? 1'($urandom_range(0, 1))
                                              : 1'(ready_mode);
            end
            ctrl_rs1_val = zero_rs ? 32'd0 : $urandom;
            ctrl_rs2_val = ($urandom_range(0, 2) == 0) ? ctrl_rs1_val : $urandom;
            #1;
            exp_en = m_run && !m_halt && alu_q.size() < DEPTH
                  && !(is_cf(inst_rdata[6:0]) && alu_q.size() > 0);
            chk("inst_en", inst_en, exp_en);
            chk("alu_en", alu_en, alu_q.size() > 0);
            if (exp_en && inst_ready) begin
                chk("inst_addr", inst_addr, m_pc[15:0]);
                if (prog.size() > 0) void'(prog.pop_front());
                model_step(inst_rdata);
            end
            m_run = 1;
        end
    endtask

    task automatic do_reset(bit sync);
        @(negedge aclk);
        alu_ready = 1'b0;
        inst_ready = 1'b0;
        if (sync) srst = 1'b1;
        else aresetn = 1'b0;
        @(negedge aclk);
        chk("rst_inst_en", inst_en, 1'b0);
        chk("rst_alu_en", alu_en, 1'b0);
        chk("rst_rd_wr", ctrl_rd_wr, 1'b0);
        chk("rst_pc", inst_addr, 16'h0000);
        srst = 1'b0;
        aresetn = 1'b1;
        m_pc = '0;
        m_halt = 0;
        alu_q.delete();
        rd_q.delete();
        #1;
        chk("rel_inst_en", inst_en, 1'b0);
        chk("rel_rd_addr", ctrl_rd_addr, 5'd0);
        chk("rel_rd_val", ctrl_rd_val, 32'd0);
        m_run = 1;
    endtask

    task automatic run_prog(int maxc);
        int c = 0;
        while (prog.size() > 0 && c < maxc) begin
            run_cycles(1);
            c++;
        end
        chk("prog_drained", prog.size(), 0);
        prog.delete();
        run_cycles(2);
    endtask

    always begin
        @(negedge aclk);
        #2;
        if (alu_en && alu_ready) begin
            if (alu_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL alu_pop: got %0h expected nothing", alu_instbus);
            end else chk("alu_instbus", alu_instbus, alu_q.pop_front());
        end
    end

    always begin
        logic [36:0] e;
        @(posedge aclk);
        #1;
        if (ctrl_rd_wr) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_wr: got write rd=%0d expected none", ctrl_rd_addr);
            end else begin
                e = rd_q.pop_front();
                chk("rd_addr", ctrl_rd_addr, e[36:32]);
                chk("rd_val", ctrl_rd_val, e[31:0]);
            end
        end else if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            chk("rd_wr", 1'b0, 1'b1);
        end
    end

    initial begin
        logic [6:0] o;
        do_reset(0);
        for (int k = 0; k < 14; k++) begin
            @(negedge aclk);
            o = pick_op(k);
            inst_rdata = {$urandom_range(0, 32'h1FF_FFFF), o};
            inst_ready = 1'b0;
            #1;
            chk("inst_error", dut.w_inst_error, !is_legal(o));
        end

        directed = 1;
        zero_rs = 1;
        ready_mode = 1;
        alu_mode = 1;
        do_reset(1);
        prog = '{{20'h00000, 5'd0, AUIPC}, {20'h00001, 5'd0, AUIPC},
                 {20'h00001, 5'd3, AUIPC}, {20'hFFFFF, 5'h18, AUIPC}};
        run_prog(20);
        chk("auipc_pc", inst_addr, 16'h1000);

        do_reset(0);
        prog = '{{20'h00000, 5'd0, JAL}, {20'h00000, 5'd3, JAL},
                 {20'h00100, 5'd5, JAL}};
        run_prog(20);
        chk("jal_pc", inst_addr, 16'h0800);

        do_reset(0);
        prog = '{{12'd0, 5'd0, 3'd0, 5'd0, JALR}, {12'd0, 5'd0, 3'd0, 5'd1, JALR},
                 {12'd1, 5'd0, 3'd0, 5'd2, JALR}, {12'd2, 5'd0, 3'd0, 5'd2, JALR}};
        run_prog(20);
        chk("jalr_pc", inst_addr, 16'h0002);

        do_reset(1);
        alu_mode = 0;
        for (int k = 0; k < 6; k++) prog.push_back({$urandom_range(0, 32'h1FF_FFFF), SYSTEM});
        run_cycles(8);
        chk("fifo_full_stall", inst_en, 1'b0);
        chk("fifo_full_left", prog.size(), 2);
        alu_mode = 1;
        run_prog(20);
        chk("fifo_resume_pc", inst_addr, 16'd24);

        directed = 0;
        zero_rs = 0;
        ready_mode = -1;
        alu_mode = -1;
        for (int r = 0; r < 40; r++) begin
            do_reset(1'($urandom_range(0, 1)));
            run_cycles(150);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/friscv_rv32i_control.md
Name: friscv_rv32i_control

Overview:
Front-end control unit of the friscv RV32I core. It owns the program counter, fetches instructions over a simple valid/ready bus and decodes the opcode. ALU-class instructions are pushed into an internal ALU instruction FIFO. Control-flow instructions (AUIPC/JAL/JALR/BRANCH) are executed locally, writing rd through a dedicated register-file port.

Parameters:
- ADDRW, 16, instruction address width
- BOOT_ADDR, 0, PC value after reset
- XLEN, 32, data/register width
- `ALU_FIFO_DEPTH (friscv_h), 4, ALU FIFO depth; `ALU_INSTBUS_W (friscv_h) is the width of alu_instbus

Ports:
- aclk in 1: clock
- aresetn in 1: asynchronous active-low reset
- srst in 1: synchronous active-high reset, same effect as aresetn
- inst_en out 1: fetch request valid
- inst_addr out ADDRW: fetch address = pc[ADDRW-1:0]
- inst_rdata in XLEN: fetched instruction
- inst_ready in 1: instruction valid; handshake = inst_en & inst_ready
- alu_en out 1: ALU FIFO non-empty (instruction valid)
- alu_ready in 1: ALU accepts instruction
- alu_instbus out `ALU_INSTBUS_W: FIFO head, decoded fields {opcode,funct3,funct7,rs1,rs2,rd,zimm,imm12,imm20,csr,shamt}
- ctrl_rs1_addr out 5: inst_rdata[19:15], combinational
- ctrl_rs1_val in XLEN: rs1 value
- ctrl_rs2_addr out 5: inst_rdata[24:20], combinational
- ctrl_rs2_val in XLEN: rs2 value
- ctrl_rd_wr out 1: rd write strobe
- ctrl_rd_addr out 5: rd index
- ctrl_rd_val out XLEN: rd data

Behaviour:
- Reset: pc=BOOT_ADDR, FIFO empty, halted=0, ctrl_rd_wr=0, ctrl_rd_addr=0, ctrl_rd_val=0, inst_en=0. inst_en rises one cycle after reset release.
- Internal inst_error is combinational on inst_rdata[6:0], independent of handshake. Legal opcodes: 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OP-IMM, 0110011 OP, 1110011 SYSTEM, 0000000 (idle/NOP). Any other opcode sets inst_error=1.
- inst_en = running & ~halted & ~fifo_full & ~(opcode is control-flow & fifo non-empty). Control-flow instructions wait until the FIFO is drained; alu_ready is not considered.
- ALU class (LUI, LOAD, STORE, OP-IMM, OP, SYSTEM) on handshake: alu_inst_wr=1 (push decoded bus), pc+=4. One instruction per cycle.
- AUIPC on handshake: pc <= pc + {imm20,12'b0}. Next cycle: ctrl_rd_wr=1, ctrl_rd_addr=rd, ctrl_rd_val=new pc. The PC does not additionally advance by 4.
- JAL: offset = sext({i[31],i[19:12],i[20],i[30:21],0}); pc <= pc+offset; rd write of old pc+4 (1-cycle strobe).
- JALR: pc <= (ctrl_rs1_val + sext(imm12)) & ~1; rd write of old pc+4.
- BRANCH: compare rs1/rs2 by funct3 (BEQ,BNE,BLT,BGE,BLTU,BGEU). Taken: pc += sext B-imm. Otherwise pc += 4. No rd write.
- Opcode 0000000 on handshake: consumed, no effect, pc unchanged.
- Illegal opcode on handshake: halted=1, inst_en held 0 until reset; nothing issued.
- ctrl_rd_wr: single-cycle pulse. It is asserted every cycle for back-to-back control instructions.
- FIFO: push when alu_inst_wr, pop when alu_en & alu_ready. Simultaneous push/pop keeps the count. Full means inst_en=0. alu_instbus is valid whenever alu_en=1.
- Reset mid-operation flushes the FIFO and restores BOOT_ADDR.
- All arithmetic is modulo 2^XLEN (wrap-around).

Test Plan:
- Each legal opcode, inst_ready=0 -> inst_error=0. Opcodes 0000001, 0101001, 1111111 -> inst_error=1.
- alu_ready=1, inst_ready=1, ALU opcodes streamed -> alu_inst_wr=1 every cycle; alu_en follows.
- alu_ready=0, inst_ready=1 with SYSTEM opcode for ALU_FIFO_DEPTH cycles -> inst_en=0 afterwards. Raising alu_ready -> inst_en returns.
- AUIPC sequence imm20=0,1,1(rd=3),FFFFF(rd=0x18) -> pc 0,0x1000,0x2000,0x1000. Each: ctrl_rd_wr=1, rd_addr matches, rd_val=pc.
- JAL imm=0 rd=0, imm=0 rd=3, imm[11]=1 rd=5 -> pc 0,0,0x800. Each: ctrl_rd_wr=1 with matching rd.
- JALR rs1_val=0, imm12=0,0,1,2 (rd=0,1,2,2) -> pc 0,0,0,2; ctrl_rd_wr=1.
